// File: rtl/spec_peak_analyze.sv
// rtl/spec_peak_analyze.sv - streaming spectral-peak detector over NBIN-bin frames
module spec_peak_analyze #(
   parameter int NBIN = 16,
   parameter int IDXW = 4,
   parameter int DW   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            bin_valid,
   input  logic [2*DW-1:0] bin_d,
   input  logic [2*DW-1:0] thresh,
   output logic            done,
   output logic [IDXW-1:0] freq,
   output logic [2*DW-1:0] peak_mag,
   output logic            peak_hit,
   output logic [7:0]      frame_cnt
);

   // Input stage: bin counter plus captured bin, tagged with its index and frame-end flag
   logic                  r_s0_valid;
   logic signed [DW-1:0]  r_s0_re;
   logic signed [DW-1:0]  r_s0_im;
   logic [IDXW-1:0]       r_s0_idx;
   logic                  r_s0_last;
   logic [IDXW-1:0]       r_idx;

   // Stage 1: squared magnitude
   logic                  r_s1_valid;
   logic [2*DW-1:0]       r_s1_mag;
   logic [IDXW-1:0]       r_s1_idx;
   logic                  r_s1_last;

   // Stage 2: running maximum of the current frame
   logic [2*DW-1:0]       r_max_mag;
   logic [IDXW-1:0]       r_max_idx;

   logic signed [2*DW-1:0] w_re_sq;
   logic signed [2*DW-1:0] w_im_sq;
   logic [2*DW-1:0]        w_mag;
   logic                   w_take;
   logic [2*DW-1:0]        w_res_mag;
   logic [IDXW-1:0]        w_res_idx;

   // Each square is at most 2^(2DW-2), so the unsigned sum peaks at 2^(2DW-1) and never wraps
   assign w_re_sq = r_s0_re * r_s0_re;
   assign w_im_sq = r_s0_im * r_s0_im;
   assign w_mag   = $unsigned(w_re_sq) + $unsigned(w_im_sq);

   // Index 0 always starts a fresh frame; a strict compare keeps the lowest index on ties
   assign w_take    = (r_s1_idx == '0) || (r_s1_mag > r_max_mag);
   assign w_res_mag = w_take ? r_s1_mag : r_max_mag;
   assign w_res_idx = w_take ? r_s1_idx : r_max_idx;

   // Capture valid bins and advance the bin counter; reset drops any bin in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx      <= '0;
         r_s0_valid <= 1'b0;
         r_s0_re    <= '0;
         r_s0_im    <= '0;
         r_s0_idx   <= '0;
         r_s0_last  <= 1'b0;
      end else begin
         r_s0_valid <= bin_valid;
         if (bin_valid) begin
            r_s0_re   <= bin_d[2*DW-1:DW];
            r_s0_im   <= bin_d[DW-1:0];
            r_s0_idx  <= r_idx;
            r_s0_last <= (r_idx == IDXW'(NBIN - 1));
            r_idx     <= r_idx + 1'b1;
         end
      end
   end

   // Register the squared magnitude alongside its index and frame-end tag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_mag   <= '0;
         r_s1_idx   <= '0;
         r_s1_last  <= 1'b0;
      end else begin
         r_s1_valid <= r_s0_valid;
         if (r_s0_valid) begin
            r_s1_mag  <= w_mag;
            r_s1_idx  <= r_s0_idx;
            r_s1_last <= r_s0_last;
         end
      end
   end

   // Track the frame maximum and publish the result on the last bin, including that bin
   always_ff @(posedge clk) begin
      if (rst) begin
         r_max_mag <= '0;
         r_max_idx <= '0;
         done      <= 1'b0;
         freq      <= '0;
         peak_mag  <= '0;
         peak_hit  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         done <= 1'b0;
         if (r_s1_valid) begin
            r_max_mag <= w_res_mag;
            r_max_idx <= w_res_idx;
            if (r_s1_last) begin
               freq      <= w_res_idx;
               peak_mag  <= w_res_mag;
               peak_hit  <= (w_res_mag >= thresh);
               done      <= 1'b1;
               frame_cnt <= frame_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spec_peak_analyze.sv
// tb/tb_spec_peak_analyze.sv - directed self-checking bench for spec_peak_analyze
module tb_spec_peak_analyze;

   logic        clk;
   logic        rst;
   logic        bin_valid;
   logic [31:0] bin_d;
   logic [31:0] thresh;
   logic        done;
   logic [3:0]  freq;
   logic [31:0] peak_mag;
   logic        peak_hit;
   logic [7:0]  frame_cnt;

   int checks;
   int errors;
   int cyc;
   int last_cyc;

   logic signed [15:0] re_a [16];
   logic signed [15:0] im_a [16];

   int          d_cyc  [$];
   logic [3:0]  d_freq [$];
   logic [31:0] d_mag  [$];
   logic        d_hit  [$];
   logic [7:0]  d_fc   [$];

   spec_peak_analyze #(.NBIN(16), .IDXW(4), .DW(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .bin_valid (bin_valid),
      .bin_d     (bin_d),
      .thresh    (thresh),
      .done      (done),
      .freq      (freq),
      .peak_mag  (peak_mag),
      .peak_hit  (peak_hit),
      .frame_cnt (frame_cnt)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to time done relative to the last bin
   always @(posedge clk) cyc <= cyc + 1;

   // Record every done pulse with the results visible in that cycle
   always @(negedge clk) begin
      if (done) begin
         d_cyc.push_back(cyc);
         d_freq.push_back(freq);
         d_mag.push_back(peak_mag);
         d_hit.push_back(peak_hit);
         d_fc.push_back(frame_cnt);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bin(input logic signed [15:0] re, input logic signed [15:0] im);
      bin_valid = 1'b1;
      bin_d     = {re, im};
      @(posedge clk);
      #1;
      bin_valid = 1'b0;
      last_cyc  = cyc;
   endtask

   task automatic send_frame(input bit gapped);
      for (int i = 0; i < 16; i++) begin
         send_bin(re_a[i], im_a[i]);
         if (gapped && (i == 0 || i == 7 || i == 15)) idle(3);
      end
   endtask

   task automatic fill(input logic signed [15:0] re, input logic signed [15:0] im);
      for (int i = 0; i < 16; i++) begin
         re_a[i] = re;
         im_a[i] = im;
      end
   endtask

   task automatic clear_log();
      d_cyc.delete();
      d_freq.delete();
      d_mag.delete();
      d_hit.delete();
      d_fc.delete();
   endtask

   // Check one recorded frame result; a missing pulse counts as a failure
   task automatic chk_result(input string tag, input int n, input int slot, input int delay,
                             input logic [3:0] f, input logic [31:0] m, input logic h,
                             input logic [7:0] fc);
      chk({tag, "_pulses"}, d_cyc.size(), n);
      if (d_cyc.size() > slot) begin
         if (delay >= 0) chk({tag, "_latency"}, d_cyc[slot] - last_cyc, delay);
         chk({tag, "_freq"}, d_freq[slot], f);
         chk({tag, "_mag"}, d_mag[slot], m);
         chk({tag, "_hit"}, d_hit[slot], h);
         chk({tag, "_fcnt"}, d_fc[slot], fc);
      end else begin
         chk({tag, "_present"}, 0, 1);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      last_cyc  = 0;
      rst       = 1'b1;
      bin_valid = 1'b0;
      bin_d     = '0;
      thresh    = '0;
      idle(2);
      chk("rst_done", done, 0);
      chk("rst_freq", freq, 0);
      chk("rst_mag", peak_mag, 0);
      chk("rst_hit", peak_hit, 0);
      chk("rst_fcnt", frame_cnt, 0);
      rst = 1'b0;
      idle(1);

      // Single peak
      clear_log();
      fill(16'sd10, 16'sd10);
      re_a[5] = 16'sd300;
      im_a[5] = -16'sd400;
      thresh = 32'd100000;
      send_frame(1'b0);
      idle(6);
      chk_result("single", 1, 0, 2, 4'd5, 32'd250000, 1'b1, 8'd1);
      chk("single_hold_freq", freq, 5);

      // Tie and threshold miss
      clear_log();
      fill(16'sd0, 16'sd0);
      re_a[3] = 16'sd1000;
      re_a[9] = 16'sd1000;
      thresh = 32'd2000000;
      send_frame(1'b0);
      idle(6);
      chk_result("tie", 1, 0, 2, 4'd3, 32'd1000000, 1'b0, 8'd2);

      // Extreme values
      clear_log();
      fill(16'sd32767, 16'sd0);
      re_a[15] = -16'sd32768;
      im_a[15] = -16'sd32768;
      send_frame(1'b0);
      idle(6);
      chk_result("extreme", 1, 0, 2, 4'd15, 32'h80000000, 1'b1, 8'd3);

      // Gapped input
      clear_log();
      fill(16'sd10, 16'sd10);
      re_a[5] = 16'sd300;
      im_a[5] = -16'sd400;
      thresh = 32'd100000;
      for (int i = 0; i < 16; i++) begin
         send_bin(re_a[i], im_a[i]);
         if (i == 15) break;
         if (i == 0 || i == 7) idle(3);
      end
      idle(6);
      chk_result("gapped", 1, 0, 2, 4'd5, 32'd250000, 1'b1, 8'd4);

      // Back-to-back frames
      clear_log();
      fill(16'sd1, 16'sd1);
      re_a[2] = 16'sd100;
      im_a[2] = 16'sd0;
      send_frame(1'b0);
      fill(16'sd1, 16'sd1);
      re_a[14] = 16'sd200;
      im_a[14] = 16'sd0;
      send_frame(1'b0);
      idle(6);
      chk_result("b2b_a", 2, 0, -1, 4'd2, 32'd10000, 1'b0, 8'd5);
      chk_result("b2b_b", 2, 1, 2, 4'd14, 32'd40000, 1'b0, 8'd6);
      if (d_cyc.size() == 2) chk("b2b_spacing", d_cyc[1] - d_cyc[0], 16);
      else chk("b2b_spacing_present", 0, 1);

      // Reset mid-frame, with a bin presented during the reset cycle
      clear_log();
      fill(16'sd200, 16'sd200);
      for (int i = 0; i < 9; i++) send_bin(re_a[i], im_a[i]);
      rst       = 1'b1;
      bin_valid = 1'b1;
      bin_d     = {16'sd200, 16'sd200};
      @(posedge clk);
      #1;
      bin_valid = 1'b0;
      rst       = 1'b0;
      chk("mid_rst_done", done, 0);
      chk("mid_rst_freq", freq, 0);
      chk("mid_rst_mag", peak_mag, 0);
      chk("mid_rst_hit", peak_hit, 0);
      chk("mid_rst_fcnt", frame_cnt, 0);
      fill(16'sd1, 16'sd0);
      re_a[0] = 16'sd50;
      send_frame(1'b0);
      idle(6);
      chk_result("after_rst", 1, 0, 2, 4'd0, 32'd2500, 1'b0, 8'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
